asmi_flash_responder: RTL and testbench

//  Serial-flash responder model: the flash-device end of the ASMI/active-serial link that the loader drives.

---
 rtl/asmi_flash_responder.sv | 212 +++++++++++++++++++++
 tb/tb_asmi_flash_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/asmi_flash_responder.sv
// Serial-flash device model for the ASMI/active-serial link (SPI mode 0), backed by a byte array and a status register.
// Define ASMI_RESP_ERASE_EN to enable D8 sector erase and C7 bulk erase; otherwise those opcodes are unsupported.
module asmi_flash_responder #(
  parameter int MEM_AW      = 10,
  parameter int PROG_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic dclk,
  input  logic sce,
  input  logic sdo,
  output logic data0,
  output logic data0_oe,
  output logic init_done,
  output logic wip,
  output logic bad_op
);
  localparam int DEPTH = 1 << MEM_AW;
  localparam int WCW   = $clog2(PROG_CYCLES + 1);
  localparam int SEC_W = (MEM_AW < 16) ? MEM_AW : 16;
  localparam logic [MEM_AW-1:0] SEC_MASK = MEM_AW'((64'd1 << SEC_W) - 64'd1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STATUS, S_IGNORE} state_t;
  typedef enum logic [2:0] {A_NONE, A_WREN, A_WRDI, A_PP, A_SEC, A_BULK} act_t;

  logic [SYNC_STAGES-1:0] r_dclk_sync, r_sce_sync, r_sdo_sync;
  logic              r_dclk_d, r_sce_d;
  logic              w_dclk_s, w_sce_s, w_sdo_s;
  logic              w_rise, w_fall, w_sce_rise, w_sce_fall;
  state_t            r_state;
  act_t              r_act;
  logic              r_armed, r_wel, r_wip, r_erase_busy;
  logic              r_data0, r_data0_oe, r_init_done, r_bad_op;
  logic [WCW-1:0]    r_wip_cnt;
  logic [4:0]        r_bitcnt;
  logic [6:0]        r_shift;
  logic [7:0]        r_tx;
  logic [2:0]        r_txcnt;
  logic [MEM_AW-1:0] r_addr, r_init_ptr, r_erase_ptr, r_erase_end;
  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        w_byte, w_status, w_tx_src;
  logic              w_erase_more;

  assign w_dclk_s     = r_dclk_sync[SYNC_STAGES-1];
  assign w_sce_s      = r_sce_sync[SYNC_STAGES-1];
  assign w_sdo_s      = r_sdo_sync[SYNC_STAGES-1];
  assign w_rise       = w_dclk_s & ~r_dclk_d;
  assign w_fall       = ~w_dclk_s & r_dclk_d;
  assign w_sce_rise   = w_sce_s & ~r_sce_d;
  assign w_sce_fall   = ~w_sce_s & r_sce_d;
  assign w_byte       = {r_shift, w_sdo_s};
  assign w_status     = {6'b0, r_wel, r_wip};
  assign w_tx_src     = (r_state == S_READ) ? r_mem[r_addr] : w_status;
  assign w_erase_more = r_erase_busy && (r_erase_ptr != r_erase_end);

  assign data0     = r_data0;
  assign data0_oe  = r_data0_oe;
  assign init_done = r_init_done;
  assign wip       = r_wip;
  assign bad_op    = r_bad_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dclk_sync <= '0;
      r_sce_sync  <= '1;
      r_sdo_sync  <= '0;
    end else begin
      r_dclk_sync <= {r_dclk_sync[SYNC_STAGES-2:0], dclk};
      r_sce_sync  <= {r_sce_sync[SYNC_STAGES-2:0], sce};
      r_sdo_sync  <= {r_sdo_sync[SYNC_STAGES-2:0], sdo};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_init_ptr   <= '0;
      r_init_done  <= 1'b0;
      r_data0      <= 1'b0;
      r_data0_oe   <= 1'b0;
      r_bad_op     <= 1'b0;
      r_wel        <= 1'b0;
      r_wip        <= 1'b0;
      r_wip_cnt    <= '0;
      r_erase_busy <= 1'b0;
      r_act        <= A_NONE;
      r_armed      <= 1'b0;
      r_bitcnt     <= '0;
      r_txcnt      <= '0;
      r_dclk_d     <= 1'b0;
      r_sce_d      <= 1'b1;
    end else begin
      r_dclk_d <= w_dclk_s;
      r_sce_d  <= w_sce_s;
      r_bad_op <= 1'b0;
      if (r_wip_cnt != '0) r_wip_cnt <= r_wip_cnt - WCW'(1);
      if (r_erase_busy) begin
        r_mem[r_erase_ptr] <= 8'hFF;
        r_erase_ptr        <= r_erase_ptr + MEM_AW'(1);
        if (r_erase_ptr == r_erase_end) r_erase_busy <= 1'b0;
      end
      // WIP (and the latched WEL) drop only once both the timer and any erase sweep are finished
      if (r_wip && (r_wip_cnt <= WCW'(1)) && !w_erase_more) begin
        r_wip <= 1'b0;
        r_wel <= 1'b0;
      end

      case (r_state)
        S_INIT: begin
          r_mem[r_init_ptr] <= 8'hFF;
          r_init_ptr        <= r_init_ptr + MEM_AW'(1);
          if (r_init_ptr == '1) begin
            r_init_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (w_sce_fall) begin
            r_state  <= S_CMD;
            r_bitcnt <= '0;
            r_txcnt  <= '0;
            r_act    <= A_NONE;
            r_armed  <= 1'b0;
          end
        end
        default: begin
          if (w_sce_rise) begin
            r_state    <= S_IDLE;
            r_data0    <= 1'b0;
            r_data0_oe <= 1'b0;
            r_bitcnt   <= '0;
            if (r_armed) begin
              case (r_act)
                A_WREN: r_wel <= 1'b1;
                A_WRDI: r_wel <= 1'b0;
                A_PP, A_SEC, A_BULK: begin
                  r_wip     <= 1'b1;
                  r_wip_cnt <= WCW'(PROG_CYCLES);
                  if (r_act != A_PP) begin
                    r_erase_busy <= 1'b1;
                    r_erase_ptr  <= (r_act == A_BULK) ? '0 : (r_addr & ~SEC_MASK);
                    r_erase_end  <= (r_act == A_BULK) ? '1 : (r_addr | SEC_MASK);
                  end
                end
                default: ;
              endcase
            end
          end else if (w_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 5'd1;
            case (r_state)
              S_CMD: begin
                if (r_bitcnt == 5'd7) begin
                  r_bitcnt <= '0;
                  r_state  <= S_IGNORE;
                  if (r_wip) begin
                    if (w_byte == 8'h05) r_state <= S_STATUS;
                  end else begin
                    case (w_byte)
                      8'h03: r_state <= S_ADDR;
                      8'h02: if (r_wel) begin r_state <= S_ADDR; r_act <= A_PP; end
                      8'h05: r_state <= S_STATUS;
                      8'h06: begin r_act <= A_WREN; r_armed <= 1'b1; end
                      8'h04: begin r_act <= A_WRDI; r_armed <= 1'b1; end
`ifdef ASMI_RESP_ERASE_EN
                      8'hD8: if (r_wel) begin r_state <= S_ADDR; r_act <= A_SEC; end
                      8'hC7: if (r_wel) begin r_act <= A_BULK; r_armed <= 1'b1; end
`endif
                      default: r_bad_op <= 1'b1;
                    endcase
                  end
                end
              end
              S_ADDR: begin
                r_addr <= {r_addr[MEM_AW-2:0], w_sdo_s};
                if (r_bitcnt == 5'd23) begin
                  r_bitcnt <= '0;
                  if (r_act == A_PP) r_state <= S_PROG;
                  else if (r_act == A_SEC) begin r_state <= S_IGNORE; r_armed <= 1'b1; end
                  else r_state <= S_READ;
                end
              end
              S_PROG: begin
                // Programming only clears bits; address wraps inside the 256-byte page
                if (r_bitcnt[2:0] == 3'd7) begin
                  r_mem[r_addr] <= r_mem[r_addr] & w_byte;
                  r_addr        <= {r_addr[MEM_AW-1:8], r_addr[7:0] + 8'd1};
                  r_armed       <= 1'b1;
                  r_bitcnt      <= '0;
                end
              end
              default: ;
            endcase
          end else if (w_fall && (r_state == S_READ || r_state == S_STATUS)) begin
            r_data0_oe <= 1'b1;
            if (r_txcnt == 3'd0) begin
              r_data0 <= w_tx_src[7];
              r_tx    <= {w_tx_src[6:0], 1'b0};
              r_txcnt <= 3'd7;
              if (r_state == S_READ) r_addr <= r_addr + MEM_AW'(1);
            end else begin
              r_data0 <= r_tx[7];
              r_tx    <= {r_tx[6:0], 1'b0};
              r_txcnt <= r_txcnt - 3'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_asmi_flash_responder.sv
// Bench for asmi_flash_responder: host-side SPI driver, table vectors, random traffic vs. a byte-array reference model.
module tb_asmi_flash_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int PROG  = 256;
  localparam int HALF  = 5;

  logic clk = 1'b0, reset = 1'b1, dclk = 1'b0, sce = 1'b1, sdo = 1'b0;
  logic data0, data0_oe, init_done, wip, bad_op;
  int n_cmp = 0, n_fail = 0, n_wip_cyc = 0, n_bad = 0, n_oe = 0;
  logic [7:0] m_mem [DEPTH];

  typedef struct {bit is_pp; logic [23:0] addr; int n; logic [31:0] data;} vec_t;
  vec_t vecs [10];

  asmi_flash_responder #(.MEM_AW(AW), .PROG_CYCLES(PROG), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .dclk(dclk), .sce(sce), .sdo(sdo),
    .data0(data0), .data0_oe(data0_oe), .init_done(init_done), .wip(wip), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wip) n_wip_cyc++;
    if (bad_op) n_bad++;
    if (data0_oe) n_oe++;
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void m_pp(input int a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      int pa = (a / 256) * 256 + ((a % 256) + i) % 256;
      m_mem[pa] = m_mem[pa] & d[31-8*i -: 8];
    end
  endfunction

  function automatic logic [31:0] m_rd(input int a, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[31-8*i -: 8] = m_mem[(a + i) % DEPTH];
    return r;
  endfunction

  task automatic xbits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      sdo = tx[i];
      repeat (HALF) @(negedge clk);
      dclk = 1'b1;
      rx[i] = data0;
      repeat (HALF) @(negedge clk);
      dclk = 1'b0;
    end
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    sce = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic txn(input logic [7:0] op, input bit use_addr, input logic [23:0] addr, input int n,
                     input logic [31:0] din, output logic [31:0] dout, output logic oe_seen);
    logic [7:0] r;
    dout = '0;
    sce = 1'b0;
    repeat (HALF) @(negedge clk);
    xbits(op, 8, r);
    if (use_addr) for (int k = 2; k >= 0; k--) xbits(addr[8*k +: 8], 8, r);
    for (int k = 0; k < n; k++) begin
      xbits(din[31-8*k -: 8], 8, r);
      dout[31-8*k -: 8] = r;
    end
    oe_seen = data0_oe;
    cs_end();
  endtask

  task automatic wait_wip_low();
    int k = 0;
    while (wip && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("wip_release", {31'b0, wip}, 32'h0);
  endtask

  task automatic pp_op(input logic [23:0] addr, input int n, input logic [31:0] d);
    logic [31:0] r;
    logic oe;
    txn(8'h06, 1'b0, 24'h0, 0, 32'h0, r, oe);
    txn(8'h02, 1'b1, addr, n, d, r, oe);
    m_pp(int'(addr[AW-1:0]), n, d);
    wait_wip_low();
  endtask

  task automatic rd_chk(input string nm, input logic [23:0] addr, input int n, input logic [31:0] exp);
    logic [31:0] r, mask;
    logic oe;
    mask = 32'hFFFF_FFFF << (8 * (4 - n));
    txn(8'h03, 1'b1, addr, n, 32'h0, r, oe);
    chk(nm, r & mask, exp & mask);
    chk({nm, "_oe"}, {31'b0, oe}, 32'h1);
  endtask

  initial begin
    logic [31:0] d, expv;
    logic [23:0] ra;
    logic [7:0] rb;
    logic oe;
    int s0, b0, o0, n, k;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    vecs[0] = '{1'b0, 24'h000000, 4, 32'hFFFFFFFF};
    vecs[1] = '{1'b0, 24'h000010, 2, 32'hA53C0000};
    vecs[2] = '{1'b1, 24'h0000FE, 4, 32'h11223344};
    vecs[3] = '{1'b0, 24'h0000FE, 2, 32'h11220000};
    vecs[4] = '{1'b0, 24'h000000, 2, 32'h33440000};
    vecs[5] = '{1'b1, 24'h000100, 1, 32'hF0000000};
    vecs[6] = '{1'b1, 24'h000100, 1, 32'h0F000000};
    vecs[7] = '{1'b0, 24'h000100, 1, 32'h00000000};
    vecs[8] = '{1'b0, 24'h0003FE, 4, 32'hFFFF3344};
    vecs[9] = '{1'b0, 24'hABCFFE, 4, 32'hFFFF3344};

    // reset and init sweep
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_outputs", {27'b0, data0, data0_oe, init_done, wip, bad_op}, 32'h0);
    repeat (DEPTH - 1) @(negedge clk);
    chk("init_not_yet", {31'b0, init_done}, 32'h0);
    @(negedge clk);
    chk("init_done", {31'b0, init_done}, 32'h1);

    // WREN, page program, status during and after the write cycle
    txn(8'h06, 1'b0, 24'h0, 0, 32'h0, d, oe);
    txn(8'h05, 1'b0, 24'h0, 1, 32'h0, d, oe);
    chk("rdsr_wel", {24'b0, d[31:24]}, 32'h02);
    s0 = n_wip_cyc;
    txn(8'h02, 1'b1, 24'h000010, 2, 32'hA53C0000, d, oe);
    m_pp(16, 2, 32'hA53C0000);
    chk("wip_after_pp", {31'b0, wip}, 32'h1);
    txn(8'h05, 1'b0, 24'h0, 1, 32'h0, d, oe);
    chk("rdsr_busy", {24'b0, d[31:24]}, 32'h03);
    wait_wip_low();
    chk("wip_duration", n_wip_cyc - s0, PROG);
    txn(8'h05, 1'b0, 24'h0, 1, 32'h0, d, oe);
    chk("rdsr_idle", {24'b0, d[31:24]}, 32'h00);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_pp) pp_op(vecs[i].addr, vecs[i].n, vecs[i].data);
      else rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].n, vecs[i].data);
    end

    for (int t = 0; t < 12; t++) begin
      ra = 24'($urandom);
      n = $urandom_range(1, 4);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) pp_op(ra, n, d);
      else begin
        expv = m_rd(int'(ra[AW-1:0]), n);
        rd_chk($sformatf("rand%0d", t), ra, n, expv);
      end
    end

    // PP without write enable, then an unsupported opcode
    s0 = n_wip_cyc;
    txn(8'h02, 1'b1, 24'h000020, 1, 32'h00000000, d, oe);
    repeat (20) @(negedge clk);
    chk("pp_no_wel_wip", n_wip_cyc - s0, 32'h0);
    rd_chk("pp_no_wel_data", 24'h000020, 1, m_rd(32, 1));
    b0 = n_bad;
    o0 = n_oe;
    txn(8'h5A, 1'b0, 24'h0, 2, 32'h0, d, oe);
    chk("badop_pulses", n_bad - b0, 32'h1);
    chk("badop_oe", n_oe - o0, 32'h0);

    // PP aborted part-way through the first data byte
    txn(8'h06, 1'b0, 24'h0, 0, 32'h0, d, oe);
    s0 = n_wip_cyc;
    sce = 1'b0;
    repeat (HALF) @(negedge clk);
    xbits(8'h02, 8, rb);
    xbits(8'h00, 8, rb);
    xbits(8'h00, 8, rb);
    xbits(8'h30, 8, rb);
    xbits(8'h00, 4, rb);
    cs_end();
    repeat (20) @(negedge clk);
    chk("abort_wip", n_wip_cyc - s0, 32'h0);
    rd_chk("abort_data", 24'h000030, 1, m_rd(48, 1));
    txn(8'h05, 1'b0, 24'h0, 1, 32'h0, d, oe);
    chk("rdsr_wel_kept", {24'b0, d[31:24]}, 32'h02);
    txn(8'h04, 1'b0, 24'h0, 0, 32'h0, d, oe);
    txn(8'h05, 1'b0, 24'h0, 1, 32'h0, d, oe);
    chk("rdsr_wrdi", {24'b0, d[31:24]}, 32'h00);

    // reset in the middle of a command re-runs the clear sweep
    pp_op(24'h000040, 1, 32'h00000000);
    rd_chk("pre_reset_data", 24'h000040, 1, m_rd(64, 1));
    sce = 1'b0;
    repeat (HALF) @(negedge clk);
    xbits(8'h03, 5, rb);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sce = 1'b1;
    dclk = 1'b0;
    chk("midreset_init", {31'b0, init_done}, 32'h0);
    k = 0;
    while (!init_done && k < 2 * DEPTH) begin
      @(negedge clk);
      k++;
    end
    chk("midreset_done", {31'b0, init_done}, 32'h1);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    repeat (2 * HALF) @(negedge clk);
    rd_chk("midreset_clear", 24'h000040, 1, m_rd(64, 1));

    // sector erase
    pp_op(24'h000050, 1, 32'h12000000);
    txn(8'h06, 1'b0, 24'h0, 0, 32'h0, d, oe);
    b0 = n_bad;
    s0 = n_wip_cyc;
    txn(8'hD8, 1'b1, 24'h000000, 0, 32'h0, d, oe);
    wait_wip_low();
`ifdef ASMI_RESP_ERASE_EN
    chk("erase_wip_long", {31'b0, (n_wip_cyc - s0) >= DEPTH}, 32'h1);
    chk("erase_badop", n_bad - b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hFF;
    rd_chk("erase_data", 24'h000050, 1, m_rd(80, 1));
`else
    chk("erase_badop", n_bad - b0, 32'h1);
    chk("erase_no_wip", n_wip_cyc - s0, 32'h0);
    rd_chk("erase_noeffect", 24'h000050, 1, m_rd(80, 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
